// File: rtl/uart_tx_axi_if.sv
// AXI4-Lite write/read channel bundle between a bus master and the UART transmitter.
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs of each channel.
interface uart_tx_axi_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/uart_tx_axi.sv
// AXI4-Lite slave feeding a byte FIFO into a UART transmitter; 10-bit frame, or 11-bit with even parity when UART_TX_PARITY_EN is defined.
// Latency: bvalid/rvalid one cycle after the accepting handshake; a popped byte drives its START bit on the next cycle.
// Backpressure: one outstanding write and one outstanding read; writes to a full FIFO are dropped and answered with SLVERR.
module uart_tx_axi #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    uart_tx_axi_if.slave axi,
    output logic         tx
);
    localparam int               PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [15:0]      BAUD_LOAD   = 16'(CLK_DIV - 1);
    localparam logic [PTR_W:0]   CNT_FULL    = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE     = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = (PTR_W)'(1);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             pop;
    logic             bit_end;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
`endif

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic             fifo_full, fifo_empty, push;
    logic [7:0]       pop_byte;
    logic [31:0]      cnt_ext;
    logic [31:0]      status;

    logic             aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q;
    logic [1:0]       bresp_q, rresp_q;
    logic [31:0]      rdata_q;
    logic             wr_fire, rd_fire, wr_is_txdata, rd_is_status;
    logic [1:0]       wr_resp;

    assign fifo_full    = (fifo_cnt == CNT_FULL);
    assign fifo_empty   = (fifo_cnt == '0);
    assign pop_byte     = fifo_mem[rd_ptr];
    assign cnt_ext      = 32'(fifo_cnt);
    assign status       = {16'h0000, cnt_ext[7:0], 5'b00000, (state_q != ST_IDLE), fifo_empty, fifo_full};

    assign wr_fire      = aw_rdy_q & axi.awvalid & axi.wvalid;
    assign rd_fire      = ar_rdy_q & axi.arvalid;
    assign wr_is_txdata = (axi.awaddr[3:0] == 4'h0);
    assign rd_is_status = (axi.araddr[3:0] == 4'h4);
    // Fullness is taken from the current count, so a pop in the same cycle cannot rescue a write.
    assign push         = wr_fire & wr_is_txdata & axi.wstrb[0] & ~fifo_full;
    assign wr_resp      = (!wr_is_txdata || (axi.wstrb[0] && fifo_full)) ? RESP_SLVERR : RESP_OKAY;
    assign bit_end      = (baud_cnt == 16'd0);

    assign axi.awready  = aw_rdy_q;
    assign axi.wready   = aw_rdy_q;
    assign axi.bvalid   = bvalid_q;
    assign axi.bresp    = bresp_q;
    assign axi.arready  = ar_rdy_q;
    assign axi.rvalid   = rvalid_q;
    assign axi.rdata    = rdata_q;
    assign axi.rresp    = rresp_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, axi.awaddr[31:4], axi.wdata[31:8], axi.wstrb[3:1],
                           axi.araddr[31:4], cnt_ext[31:8]};

    // Write channel: one-cycle joint AW/W accept, then hold the response until bready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
        end else begin
            aw_rdy_q <= axi.awvalid & axi.wvalid & ~bvalid_q & ~aw_rdy_q;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bvalid_q && axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read channel: one-cycle AR accept, then hold rdata/rresp until rready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_rdy_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            rresp_q  <= 2'b00;
        end else begin
            ar_rdy_q <= axi.arvalid & ~rvalid_q & ~ar_rdy_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_is_status ? status : 32'h0;
                rresp_q  <= rd_is_status ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_q && axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // FIFO storage: data only, pointers and count carry the valid state.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= axi.wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Serializer state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Serializer next state, FIFO pop and line level; tx follows the state so reset raises it at once.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx = shreg[0];
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx = par_q;
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit timer and shifter: a pop loads a fresh byte and restarts the bit period.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else if (pop) begin
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= 3'd0;
            shreg    <= pop_byte;
`ifdef UART_TX_PARITY_EN
            par_q    <= ^pop_byte;
`endif
        end else if (state_q != ST_IDLE) begin
            baud_cnt <= bit_end ? BAUD_LOAD : baud_cnt - 16'd1;
            if (state_q == ST_DATA && bit_end) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_axi.sv
// Bench for uart_tx_axi: a fast DUT (CLK_DIV=4) checks framing, a slow one (FIFO_DEPTH=4) checks FIFO overflow.
// Latency: n/a.
// Backpressure: bready/rready held low for a few cycles to check response hold.
module tb_uart_tx_axi;
    localparam int DIV_A = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic aclk, aresetn, sel, mon_ignore;
    logic tx_a, tx_b;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned last_start = 0;
    int unsigned last_period = 0;
    logic [7:0]  exp_q[$];
    logic [1:0]  bresp_q[$];
    logic [33:0] rd_q[$];

    uart_tx_axi_if bus_a();
    uart_tx_axi_if bus_b();

    uart_tx_axi #(.CLK_DIV(DIV_A), .FIFO_DEPTH(8)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .axi(bus_a), .tx(tx_a));
    uart_tx_axi #(.CLK_DIV(1000), .FIFO_DEPTH(4)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .axi(bus_b), .tx(tx_b));

    assign bus_a.awvalid = m_awvalid & ~sel;
    assign bus_a.wvalid  = m_wvalid & ~sel;
    assign bus_a.bready  = m_bready & ~sel;
    assign bus_a.arvalid = m_arvalid & ~sel;
    assign bus_a.rready  = m_rready & ~sel;
    assign bus_a.awaddr  = m_awaddr;
    assign bus_a.wdata   = m_wdata;
    assign bus_a.wstrb   = m_wstrb;
    assign bus_a.araddr  = m_araddr;
    assign bus_b.awvalid = m_awvalid & sel;
    assign bus_b.wvalid  = m_wvalid & sel;
    assign bus_b.bready  = m_bready & sel;
    assign bus_b.arvalid = m_arvalid & sel;
    assign bus_b.rready  = m_rready & sel;
    assign bus_b.awaddr  = m_awaddr;
    assign bus_b.wdata   = m_wdata;
    assign bus_b.wstrb   = m_wstrb;
    assign bus_b.araddr  = m_araddr;

    assign s_awready = sel ? bus_b.awready : bus_a.awready;
    assign s_wready  = sel ? bus_b.wready  : bus_a.wready;
    assign s_bvalid  = sel ? bus_b.bvalid  : bus_a.bvalid;
    assign s_bresp   = sel ? bus_b.bresp   : bus_a.bresp;
    assign s_arready = sel ? bus_b.arready : bus_a.arready;
    assign s_rvalid  = sel ? bus_b.rvalid  : bus_a.rvalid;
    assign s_rdata   = sel ? bus_b.rdata   : bus_a.rdata;
    assign s_rresp   = sel ? bus_b.rresp   : bus_a.rresp;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input int bdly);
        int n;
        logic [1:0] want, r0;
        logic stable;
        bresp_q.push_back(exp_resp);
        @(posedge aclk); #1;
        m_awaddr = addr; m_wdata = data; m_wstrb = strb;
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!(s_awready && s_wready) && n < 50) begin @(negedge aclk); n++; end
        if (!(s_awready && s_wready)) begin
            m_awvalid = 1'b0; m_wvalid = 1'b0;
            void'(bresp_q.pop_front());
            check_eq("aw_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge aclk); #1;
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        @(negedge aclk);
        check_eq("aw_one_cycle", {31'd0, s_awready}, 32'd0);
        check_eq("bvalid_next", {31'd0, s_bvalid}, 32'd1);
        r0 = s_bresp; stable = 1'b1;
        for (int i = 0; i < bdly; i++) begin
            @(negedge aclk);
            if (!s_bvalid || s_bresp !== r0) stable = 1'b0;
        end
        if (bdly > 0) check_eq("b_hold", {31'd0, stable}, 32'd1);
        want = bresp_q.pop_front();
        check_eq("bresp", {30'd0, s_bresp}, {30'd0, want});
        m_bready = 1'b1;
        @(posedge aclk); #1;
        m_bready = 1'b0;
        @(negedge aclk);
        check_eq("bvalid_drop", {31'd0, s_bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int rdly);
        int n;
        logic [33:0] want;
        logic [31:0] d0;
        logic stable;
        rd_q.push_back({exp_resp, exp_data});
        @(posedge aclk); #1;
        m_araddr = addr; m_arvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_arready && n < 50) begin @(negedge aclk); n++; end
        if (!s_arready) begin
            m_arvalid = 1'b0;
            void'(rd_q.pop_front());
            check_eq("ar_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge aclk); #1;
        m_arvalid = 1'b0;
        @(negedge aclk);
        check_eq("ar_one_cycle", {31'd0, s_arready}, 32'd0);
        check_eq("rvalid_next", {31'd0, s_rvalid}, 32'd1);
        d0 = s_rdata; stable = 1'b1;
        for (int i = 0; i < rdly; i++) begin
            @(negedge aclk);
            if (!s_rvalid || s_rdata !== d0) stable = 1'b0;
        end
        if (rdly > 0) check_eq("r_hold", {31'd0, stable}, 32'd1);
        want = rd_q.pop_front();
        check_eq("rdata", s_rdata, want[31:0]);
        check_eq("rresp", {30'd0, s_rresp}, {30'd0, want[33:32]});
        m_rready = 1'b1;
        @(posedge aclk); #1;
        m_rready = 1'b0;
        @(negedge aclk);
        check_eq("rvalid_drop", {31'd0, s_rvalid}, 32'd0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(negedge aclk); n++; end
        check_eq("tx_drain", exp_q.size(), 32'd0);
    endtask

    // Frame monitor on dut_a: compares the line every cycle against the expected frame of the queued byte.
    initial begin : tx_mon
        logic [7:0]    mb;
        logic [FB-1:0] fr;
        int            errs;
        forever begin
            @(negedge aclk);
            if (aresetn && !mon_ignore && tx_a === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    mb = exp_q[0];
`ifdef UART_TX_PARITY_EN
                    fr = {1'b1, ^mb, mb, 1'b0};
`else
                    fr = {1'b1, mb, 1'b0};
`endif
                    last_period = cyc - last_start;
                    last_start  = cyc;
                    errs = 0;
                    for (int k = 0; k < FB * DIV_A; k++) begin
                        if (k > 0) @(negedge aclk);
                        if (tx_a !== fr[k / DIV_A]) errs++;
                    end
                    void'(exp_q.pop_front());
                    check_eq("frame_cycles", errs, 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        logic [7:0] b;
        int lows;
        aresetn = 1'b0; sel = 1'b0; mon_ignore = 1'b0;
        m_awvalid = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0; m_arvalid = 1'b0; m_rready = 1'b0;
        m_awaddr = '0; m_wdata = '0; m_wstrb = '0; m_araddr = '0;
        repeat (3) @(negedge aclk);
        check_eq("rst_tx_a", {31'd0, tx_a}, 32'd1);
        check_eq("rst_tx_b", {31'd0, tx_b}, 32'd1);
        check_eq("rst_handshakes", {28'd0, bus_a.awready, bus_a.wready, bus_a.arready, bus_a.bvalid}, 32'd0);
        check_eq("rst_rvalid", {31'd0, bus_a.rvalid}, 32'd0);
        check_eq("rst_rdata", bus_a.rdata, 32'd0);
        check_eq("rst_resps", {28'd0, bus_a.bresp, bus_a.rresp}, 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        axi_read(32'h4, 32'h0000_0002, OKAY, 0);

        exp_q.push_back(8'h55);
        axi_write(32'h0, 32'h0000_0055, 4'b0001, OKAY, 2);
        wait_drain(200);
        axi_read(32'h4, 32'h0000_0002, OKAY, 0);

        axi_write(32'h0, 32'h0000_00FF, 4'b1110, OKAY, 0);
        axi_read(32'h4, 32'h0000_0002, OKAY, 0);

        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            axi_write(32'h0, {24'hABCDEF, b}, 4'b1111, OKAY, 0);
            wait_drain(200);
        end

`ifdef UART_TX_PARITY_EN
        exp_q.push_back(8'h07);
        axi_write(32'h0, 32'h0000_0007, 4'b0001, OKAY, 0);
        wait_drain(200);
        exp_q.push_back(8'h03);
        axi_write(32'h0, 32'h0000_0003, 4'b0001, OKAY, 0);
        wait_drain(200);
`endif

        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        axi_write(32'h0, 32'h0000_00A1, 4'b0001, OKAY, 0);
        axi_write(32'h0, 32'h0000_00B2, 4'b0001, OKAY, 0);
        wait_drain(400);
        check_eq("b2b_period", last_period, FB * DIV_A);
        axi_read(32'h4, 32'h0000_0002, OKAY, 0);

        axi_read(32'h8, 32'h0, SLVERR, 3);
        axi_write(32'h4, 32'h0000_0011, 4'b1111, SLVERR, 0);
        axi_read(32'h0, 32'h0, SLVERR, 0);
        axi_write(32'hC, 32'h0000_0022, 4'b1111, SLVERR, 3);
        axi_read(32'h4, 32'h0000_0002, OKAY, 3);

        sel = 1'b1;
        axi_write(32'h0, 32'h0000_0011, 4'b0001, OKAY, 0);
        for (int i = 0; i < 4; i++) axi_write(32'h0, 32'h0000_0021 + i, 4'b0001, OKAY, 0);
        axi_write(32'h0, 32'h0000_0025, 4'b0001, SLVERR, 0);
        axi_read(32'h4, 32'h0000_0405, OKAY, 0);
        sel = 1'b0;

        mon_ignore = 1'b1;
        axi_write(32'h0, 32'h0000_0000, 4'b0001, OKAY, 0);
        repeat (8) @(posedge aclk);
        #2;
        check_eq("tx_low_pre_reset", {31'd0, tx_a}, 32'd0);
        aresetn = 1'b0;
        #1;
        check_eq("tx_async_reset", {31'd0, tx_a}, 32'd1);
        repeat (3) @(negedge aclk);
        check_eq("rst2_outputs", {29'd0, tx_a, bus_a.bvalid, bus_a.rvalid}, 32'd4);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        mon_ignore = 1'b0;
        axi_read(32'h4, 32'h0000_0002, OKAY, 0);
        sel = 1'b1;
        axi_read(32'h4, 32'h0000_0002, OKAY, 0);
        sel = 1'b0;
        lows = 0;
        repeat (60) begin
            @(negedge aclk);
            if (tx_a !== 1'b1 || tx_b !== 1'b1) lows++;
        end
        check_eq("tx_quiet_after_reset", lows, 32'd0);
        check_eq("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
